// File: rtl/div_unit_if.sv
// Handshake and result bundle between main control and the multicycle divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             DivStart;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivDone;
    logic             DivZero;
    logic             Busy;

    modport master (
        output DivStart, A, B,
        input  Hi, Lo, DivDone, DivZero, Busy
    );

    modport slave (
        input  DivStart, A, B,
        output Hi, Lo, DivDone, DivZero, Busy
    );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on Lo, remainder on Hi.
// One iteration per clock on operand magnitudes, signs applied on the final step.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sq_q, sq_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             take;

    always_comb begin
        abs_a = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
        abs_b = bus.B[WIDTH-1] ? ('0 - bus.B) : bus.B;
        // Compare on WIDTH+1 bits; once taken, the difference always fits in WIDTH.
        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        take     = (rem_sh >= {1'b0, dvsr_q});
        rem_step = take ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvsr_d  = dvsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sq_d    = sq_q;

        unique case (state_q)
            IDLE: begin
                if (bus.DivStart) begin
                    if (bus.B == '0) begin
                        state_d = ZERO;
                    end else begin
                        state_d = RUN;
                        rem_d   = '0;
                        dvd_d   = abs_a;
                        dvsr_d  = abs_b;
                        cnt_d   = CNT_W'(WIDTH);
                        sa_d    = bus.A[WIDTH-1];
                        sq_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    end
                end
            end
            RUN: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    lo_d    = sq_q ? ('0 - quo_step) : quo_step;
                    hi_d    = sa_q ? ('0 - rem_step) : rem_step;
                end
            end
            DONE:    state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvsr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvsr_q  <= dvsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sq_q    <= sq_d;
        end
    end

    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.DivDone = (state_q == DONE);
    assign bus.DivZero = (state_q == ZERO);
    assign bus.Busy    = (state_q != IDLE);

endmodule
